// File: rtl/spi_pkg.sv
// Types and constants shared by the SPI read and write masters on the ADC config bus.
package spi_pkg;

    localparam int HALF_PERIOD_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD_LOW,
        CMD_HIGH,
        DAT_LOW,
        DAT_HIGH,
        FINISH
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_read_if.sv
// Register-block side of the SPI read master: start request, instruction, readback and status.
interface spi_read_if #(
    parameter int INSTR_WIDTH = 8,
    parameter int DATA_WIDTH  = 8
);
    logic                   en;
    logic [INSTR_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   busy;
    logic                   done;

    modport master (output en, instr, input rd_data, busy, done);
    modport slave  (input en, instr, output rd_data, busy, done);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit, reset value 0.
module sync_2ff (
    input  logic aclk,
    input  logic aresetn,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_read.sv
// 3-wire SPI read master (mode 3): shifts an instruction out on sdio, turns the line
// around on the falling edge after the last command bit, then samples the readback word.
module spi_read
    import spi_pkg::*;
#(
    parameter int INSTR_WIDTH = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
    input  logic       aclk,
    input  logic       aresetn,
    spi_read_if.slave  cfg,
    output logic       n_cs,
    output logic       sclk,
    output logic       sdio_o,
    output logic       sdio_t,
    input  logic       sdio_i
);
    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = (max_int(INSTR_WIDTH, DATA_WIDTH) > 1) ?
                        $clog2(max_int(INSTR_WIDTH, DATA_WIDTH)) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] I_LAST = BW'(INSTR_WIDTH - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [INSTR_WIDTH-1:0] isr_q, isr_d;
    logic [DATA_WIDTH-1:0]  dsr_q, dsr_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic n_cs_q, n_cs_d, sclk_q, sclk_d, sdio_o_q, sdio_o_d, sdio_t_q, sdio_t_d;
    logic busy_q, busy_d, done_q, done_d;
    logic sdi_s;

    sync_2ff u_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       (sdio_i),
        .q       (sdi_s)
    );

    wire p_last = (pcnt_q == P_LAST);

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        bcnt_d    = bcnt_q;
        isr_d     = isr_q;
        dsr_d     = dsr_q;
        rd_data_d = rd_data_q;
        n_cs_d    = n_cs_q;
        sclk_d    = sclk_q;
        sdio_o_d  = sdio_o_q;
        sdio_t_d  = sdio_t_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // Every timed state runs HALF_PERIOD cycles; the counter restarts on each transition.
        if (state_q != IDLE) pcnt_d = p_last ? '0 : pcnt_q + PW'(1);
        case (state_q)
            IDLE: begin
                if (cfg.en) begin
                    isr_d    = cfg.instr;
                    dsr_d    = '0;
                    pcnt_d   = '0;
                    bcnt_d   = '0;
                    n_cs_d   = 1'b0;
                    sclk_d   = 1'b0;
                    sdio_o_d = cfg.instr[INSTR_WIDTH-1];
                    sdio_t_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = CMD_LOW;
                end
            end
            CMD_LOW: if (p_last) begin
                sclk_d  = 1'b1;
                state_d = CMD_HIGH;
            end
            CMD_HIGH: if (p_last) begin
                sclk_d = 1'b0;
                if (bcnt_q == I_LAST) begin
                    // Release sdio on this falling edge; the ADC drives its first bit now.
                    sdio_t_d = 1'b1;
                    sdio_o_d = 1'b1;
                    bcnt_d   = '0;
                    state_d  = DAT_LOW;
                end else begin
                    sdio_o_d = isr_q[INSTR_WIDTH-2];
                    isr_d    = isr_q << 1;
                    bcnt_d   = bcnt_q + BW'(1);
                    state_d  = CMD_LOW;
                end
            end
            DAT_LOW: if (p_last) begin
                sclk_d  = 1'b1;
                state_d = DAT_HIGH;
            end
            DAT_HIGH: if (p_last) begin
                dsr_d = {dsr_q[DATA_WIDTH-2:0], sdi_s};
                if (bcnt_q == D_LAST) begin
                    bcnt_d  = '0;
                    state_d = FINISH;
                end else begin
                    sclk_d  = 1'b0;
                    bcnt_d  = bcnt_q + BW'(1);
                    state_d = DAT_LOW;
                end
            end
            FINISH: if (p_last) begin
                n_cs_d    = 1'b1;
                sdio_t_d  = 1'b0;
                sdio_o_d  = 1'b1;
                busy_d    = 1'b0;
                rd_data_d = dsr_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                pcnt_d    = '0;
                bcnt_d    = '0;
                isr_d     = '0;
                dsr_d     = '0;
                rd_data_d = '0;
                n_cs_d    = 1'b1;
                sclk_d    = 1'b1;
                sdio_o_d  = 1'b1;
                sdio_t_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            bcnt_q    <= '0;
            isr_q     <= '0;
            dsr_q     <= '0;
            rd_data_q <= '0;
            n_cs_q    <= 1'b1;
            sclk_q    <= 1'b1;
            sdio_o_q  <= 1'b1;
            sdio_t_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            bcnt_q    <= bcnt_d;
            isr_q     <= isr_d;
            dsr_q     <= dsr_d;
            rd_data_q <= rd_data_d;
            n_cs_q    <= n_cs_d;
            sclk_q    <= sclk_d;
            sdio_o_q  <= sdio_o_d;
            sdio_t_q  <= sdio_t_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign n_cs        = n_cs_q;
    assign sclk        = sclk_q;
    assign sdio_o      = sdio_o_q;
    assign sdio_t      = sdio_t_q;
    assign cfg.rd_data = rd_data_q;
    assign cfg.busy    = busy_q;
    assign cfg.done    = done_q;
endmodule

// File: tb/tb_spi_read.sv
// Directed bench for spi_read: default instance plus a 16/16-bit, HALF_PERIOD=3 instance,
// each with a small ADC model that drives readback on falling sclk while sdio is released.
module tb_spi_read;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    spi_read_if #(.INSTR_WIDTH(8), .DATA_WIDTH(8)) cfg ();
    logic n_cs, sclk, sdio_o, sdio_t;
    logic sdio_i = 1'b0;

    spi_read #(.INSTR_WIDTH(8), .DATA_WIDTH(8), .HALF_PERIOD(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg(cfg),
        .n_cs(n_cs), .sclk(sclk), .sdio_o(sdio_o), .sdio_t(sdio_t), .sdio_i(sdio_i)
    );

    spi_read_if #(.INSTR_WIDTH(16), .DATA_WIDTH(16)) cfg16 ();
    logic n_cs16, sclk16, sdio_o16, sdio_t16;
    logic sdio_i16 = 1'b0;

    spi_read #(.INSTR_WIDTH(16), .DATA_WIDTH(16), .HALF_PERIOD(3)) dut16 (
        .aclk(aclk), .aresetn(aresetn), .cfg(cfg16),
        .n_cs(n_cs16), .sclk(sclk16), .sdio_o(sdio_o16), .sdio_t(sdio_t16), .sdio_i(sdio_i16)
    );

    // ADC models and command-bit capture
    logic [7:0]  resp8 = 8'h00;
    logic [15:0] resp16 = 16'h0000;
    int idx8 = 7, idx16 = 15;
    int fall_cnt = 0, t_fall = 0, cmd_n = 0;
    logic t_seen = 1'b0;
    logic [7:0] cmd_cap = 8'h00;

    always @(negedge sclk) begin
        fall_cnt++;
        if (sdio_t) begin
            if (!t_seen) begin
                t_seen = 1'b1;
                t_fall = fall_cnt;
            end
            if (idx8 >= 0) sdio_i = resp8[idx8];
            idx8--;
        end else idx8 = 7;
    end

    always @(posedge sclk) begin
        if (!n_cs && !sdio_t) begin
            cmd_cap = {cmd_cap[6:0], sdio_o};
            cmd_n++;
        end
    end

    always @(negedge sclk16) begin
        if (sdio_t16) begin
            if (idx16 >= 0) sdio_i16 = resp16[idx16];
            idx16--;
        end else idx16 = 15;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one transaction on the default instance; optional extra en pulse at sample pulse_at.
    task automatic run(input logic [7:0] ins, input logic [7:0] resp, input int pulse_at,
                       input int window, output int d_at, output int d_cnt, output int low);
        @(negedge aclk);
        cfg.instr = ins;
        resp8 = resp;
        cfg.en = 1'b1;
        fall_cnt = 0; t_seen = 1'b0; cmd_cap = 8'h00; cmd_n = 0;
        d_at = -1; d_cnt = 0; low = 0;
        for (int k = 1; k <= window; k++) begin
            @(negedge aclk);
            cfg.en = (k == pulse_at);
            if (!n_cs && d_at < 0) low++;
            if (cfg.done) begin
                d_cnt++;
                if (d_at < 0) d_at = k;
            end
        end
    endtask

    int d_at, d_cnt, low, d1, d2, hi_cnt, bl_cnt, seen;

    initial begin
        cfg.en = 1'b0; cfg.instr = 8'h00;
        cfg16.en = 1'b0; cfg16.instr = 16'h0000;
        repeat (3) @(negedge aclk);
        check("rst_n_cs", n_cs, 1);
        check("rst_sclk", sclk, 1);
        check("rst_sdio_o", sdio_o, 1);
        check("rst_sdio_t", sdio_t, 0);
        check("rst_rd_data", cfg.rd_data, 0);
        check("rst_busy_done", {cfg.busy, cfg.done}, 0);
        aresetn = 1'b1;

        // 1: basic read
        run(8'h81, 8'hA5, 0, 200, d_at, d_cnt, low);
        check("t1_cmd_bits", cmd_cap, 8'h81);
        check("t1_cmd_edges", cmd_n, 8);
        check("t1_turnaround_fall", t_fall, 9);
        check("t1_done_at", d_at, 133);
        check("t1_done_cnt", d_cnt, 1);
        check("t1_ncs_low", low, 132);
        check("t1_rd_data", cfg.rd_data, 8'hA5);

        // 2: bit order
        run(8'h80, 8'h01, 0, 200, d_at, d_cnt, low);
        check("t2a_rd_data", cfg.rd_data, 8'h01);
        check("t2a_cmd_bits", cmd_cap, 8'h80);
        run(8'h83, 8'hFF, 0, 200, d_at, d_cnt, low);
        check("t2b_rd_data", cfg.rd_data, 8'hFF);
        check("t2b_done_at", d_at, 133);

        // 3: en held high for 300 cycles
        @(negedge aclk);
        cfg.instr = 8'h81; resp8 = 8'h3C; cfg.en = 1'b1;
        d1 = -1; d2 = -1; d_cnt = 0; hi_cnt = 0; bl_cnt = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge aclk);
            if (cfg.done) begin
                d_cnt++;
                if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
            end
            if (n_cs) hi_cnt++;
            if (!cfg.busy) bl_cnt++;
        end
        cfg.en = 1'b0;
        check("t3_done_cnt", d_cnt, 2);
        check("t3_done1_at", d1, 133);
        check("t3_done2_at", d2, 266);
        check("t3_ncs_high", hi_cnt, 2);
        check("t3_busy_low", bl_cnt, 2);
        check("t3_rd_data", cfg.rd_data, 8'h3C);
        seen = 0;
        for (int k = 0; k < 200 && seen == 0; k++) begin
            @(negedge aclk);
            if (cfg.done) seen = 1;
        end
        check("t3_drain_done", seen, 1);

        // 4: reset during the 5th data bit
        @(negedge aclk);
        cfg.instr = 8'h81; resp8 = 8'h96; cfg.en = 1'b1; fall_cnt = 0;
        @(negedge aclk);
        cfg.en = 1'b0;
        for (int k = 0; k < 300 && fall_cnt < 13; k++) @(negedge aclk);
        check("t4_reached_bit5", fall_cnt, 13);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        check("t4_n_cs", n_cs, 1);
        check("t4_sclk", sclk, 1);
        check("t4_sdio_t", sdio_t, 0);
        check("t4_sdio_o", sdio_o, 1);
        check("t4_rd_data", cfg.rd_data, 0);
        d_cnt = 0; hi_cnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge aclk);
            if (cfg.done) d_cnt++;
            if (n_cs) hi_cnt++;
        end
        check("t4_no_done", d_cnt, 0);
        check("t4_idle_ncs", hi_cnt, 150);
        run(8'h81, 8'h5A, 0, 200, d_at, d_cnt, low);
        check("t4_after_done_at", d_at, 133);
        check("t4_after_rd_data", cfg.rd_data, 8'h5A);

        // 5: en pulse while busy is ignored
        run(8'h81, 8'hC3, 50, 200, d_at, d_cnt, low);
        check("t5_done_cnt", d_cnt, 1);
        check("t5_done_at", d_at, 133);
        check("t5_ncs_low", low, 132);
        check("t5_rd_data", cfg.rd_data, 8'hC3);
        repeat (20) @(negedge aclk);
        check("t5_rd_data_stable", cfg.rd_data, 8'hC3);

        // 6: 16-bit instance, HALF_PERIOD=3
        @(negedge aclk);
        cfg16.instr = 16'h8123; resp16 = 16'hBEEF; cfg16.en = 1'b1;
        d_at = -1; low = 0;
        for (int k = 1; k <= 260; k++) begin
            @(negedge aclk);
            cfg16.en = 1'b0;
            if (!n_cs16 && d_at < 0) low++;
            if (cfg16.done && d_at < 0) d_at = k;
        end
        check("t6_rd_data", cfg16.rd_data, 16'hBEEF);
        check("t6_ncs_low", low, 195);
        check("t6_done_at", d_at, 196);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
